// File: rtl/sr_latch_seq_ctrl.sv
// Set/reset/toggle sequencer driving one sr_latch with guarded, fixed-width pulses.
// Define SRLC_VERIFY_EN to add the Q/Qbar feedback check state and sticky err.
module sr_latch_seq_ctrl #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int SETTLE_TO = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             S,
    output logic             R,
    input  logic             q_in,
    input  logic             qbar_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cmd_cnt,
    output logic             err
);

    localparam int MAX_PG = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int MAX_C  = (MAX_PG > SETTLE_TO) ? MAX_PG : SETTLE_TO;
    localparam int TW     = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_TOG = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        CHECK
    } state_t;

    state_t        state;
    logic [TW-1:0] tmr;
    logic          accept;
    logic          set_op;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;

    // TOGGLE picks the pulse that flips the latch's current Q
    assign set_op = (cmd_op == OP_SET) |
                    ((cmd_op == OP_TOG) & ~q_in);

`ifdef SRLC_VERIFY_EN
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_TO - 1);

    logic exp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            S       <= 1'b0;
            R       <= 1'b0;
            done    <= 1'b0;
            cmd_cnt <= '0;
            tmr     <= '0;
            exp_q   <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_NOP) begin
                            done <= 1'b1;
                        end else begin
                            state <= PULSE;
                            S     <= set_op;
                            R     <= ~set_op;
                            exp_q <= set_op;
                            tmr   <= PULSE_LD;
                        end
                    end
                end
                PULSE: begin
                    if (tmr == '0) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        state <= GAP;
                        tmr   <= GAP_LD;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                GAP: begin
                    if (tmr == '0) begin
                        state <= CHECK;
                        tmr   <= SETTLE_LD;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                CHECK: begin
                    if (q_in == exp_q && qbar_in == ~exp_q) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        cmd_cnt <= cmd_cnt + CNT_W'(1);
                    end else if (tmr == '0) begin
                        err     <= 1'b1;
                        state   <= IDLE;
                        done    <= 1'b1;
                        cmd_cnt <= cmd_cnt + CNT_W'(1);
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_fb;

    assign unused_fb = qbar_in;
    assign err       = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            S       <= 1'b0;
            R       <= 1'b0;
            done    <= 1'b0;
            cmd_cnt <= '0;
            tmr     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_NOP) begin
                            done <= 1'b1;
                        end else begin
                            state <= PULSE;
                            S     <= set_op;
                            R     <= ~set_op;
                            tmr   <= PULSE_LD;
                        end
                    end
                end
                PULSE: begin
                    if (tmr == '0) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        state <= GAP;
                        tmr   <= GAP_LD;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                GAP: begin
                    if (tmr == '0) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        cmd_cnt <= cmd_cnt + CNT_W'(1);
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sr_latch_seq_ctrl.sv
// Scoreboard bench for sr_latch_seq_ctrl with a behavioural latch on the feedback path.
// Expected pulses, done cycles and counts come from a cycle-indexed reference model.
module tb_sr_latch_seq_ctrl;

    localparam int P  = 4;
    localparam int G  = 2;
    localparam int ST = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready, S, R, busy, done, err;
    logic [7:0] cmd_cnt;
    logic       q_in, qbar_in;
    logic       lq = 1'b0;
    bit         stuck = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cyc;
        int cnt;
        bit e;
    } exp_t;

    exp_t sb[$];
    bit   exp_s[int];
    bit   exp_r[int];
    int   cyc = 0;
    int   free_at = 0;
    int   cnt_m = 0;
    int   acc_cnt = 0;
    bit   armed = 1'b0;
    bit   err_m = 1'b0;
    bit   prev_rst = 1'b0;

    sr_latch_seq_ctrl #(
        .PULSE_CYC(P),
        .GAP_CYC  (G),
        .SETTLE_TO(ST),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_ready(cmd_ready),
        .S        (S),
        .R        (R),
        .q_in     (q_in),
        .qbar_in  (qbar_in),
        .busy     (busy),
        .done     (done),
        .cmd_cnt  (cmd_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural SR latch; stuck forces Q low to emulate a dead latch
    always @(S or R) begin
        if (S === 1'b1) lq = 1'b1;
        else if (R === 1'b1) lq = 1'b0;
    end
    assign q_in    = stuck ? 1'b0 : lq;
    assign qbar_in = ~q_in;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   so;
        int   lat;
        bit   fail;
        bit   es, er;
        cyc++;
        if (armed) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cyc", cyc, e.cyc);
                    chk("done_cnt", cmd_cnt, e.cnt);
                    err_m |= e.e;
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("missed_done", 0, 1);
            end
            es = exp_s.exists(cyc) ? exp_s[cyc] : 1'b0;
            er = exp_r.exists(cyc) ? exp_r[cyc] : 1'b0;
            chk("s", S, es);
            chk("r", R, er);
            chk("ready", cmd_ready, cyc >= free_at);
            chk("busy", busy, cyc < free_at);
            chk("err", err, err_m);
            if (prev_rst) chk("reset_cnt", cmd_cnt, 0);
        end
        prev_rst = !rst_n;
        if (!rst_n) begin
            armed   = 1'b1;
            sb.delete();
            exp_s.delete();
            exp_r.delete();
            free_at = cyc + 1;
            cnt_m   = 0;
            err_m   = 1'b0;
        end else if (armed && cmd_valid && cyc >= free_at) begin
            acc_cnt++;
            if (cmd_op == 2'b00) begin
                sb.push_back('{cyc + 1, cnt_m, 1'b0});
            end else begin
                so = (cmd_op == 2'b01) || (cmd_op == 2'b11 && !q_in);
                for (int i = 1; i <= P; i++) begin
                    exp_s[cyc + i] = so;
                    exp_r[cyc + i] = !so;
                end
                lat  = P + G + 1;
                fail = 1'b0;
`ifdef SRLC_VERIFY_EN
                fail = stuck && so;
                lat  = lat + (fail ? ST : 1);
`endif
                cnt_m   = (cnt_m + 1) % 256;
                free_at = cyc + lat;
                sb.push_back('{cyc + lat, cnt_m, fail});
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(logic [1:0] op);
        int a0;
        int k;
        a0 = acc_cnt;
        k  = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (acc_cnt == a0 && k < 60) begin
            step(1);
            k++;
        end
        if (acc_cnt == a0) chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        issue(2'b01);
        issue(2'b11);
        issue(2'b11);
        issue(2'b10);
        issue(2'b00);
        issue(2'b11);
        issue(2'b00);
        issue(2'b00);
        issue(2'b01);
        step(10);
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_op    = 2'($urandom_range(0, 3));
            step(1);
        end
        cmd_valid = 1'b0;
        step(12);
        issue(2'b01);
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(12);
`ifdef SRLC_VERIFY_EN
        stuck = 1'b1;
        issue(2'b01);
        step(20);
        stuck = 1'b0;
        issue(2'b10);
        step(12);
`endif
        cmd_valid = 1'b0;
        step(20);
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
